// File: rtl/axil_cmd_pkg.sv
// axil_cmd_pkg: shared FSM state type and AXI response codes for the command master
package axil_cmd_pkg;
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_e;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axil_cmd_timer.sv
// axil_cmd_timer: per-transaction cycle budget; expired marks the last allowed busy cycle
module axil_cmd_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    logic [CW-1:0] cnt_q, cnt_d;
    // Saturates at LIMIT so a handshake that wins the tie still sees the budget exhausted
    assign expired = (TIMEOUT > 0) && run && (cnt_q >= LIMIT);
    assign cnt_d = clear ? '0 : ((TIMEOUT > 0) && run && !expired) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding command port to AXI4-Lite master with timeout abort
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] axil_awaddr,
    output logic [2:0]        axil_awprot,
    output logic              axil_awvalid,
    input  logic              axil_awready,
    output logic [DATA_W-1:0] axil_wdata,
    output logic [STRB_W-1:0] axil_wstrb,
    output logic              axil_wvalid,
    input  logic              axil_wready,
    input  logic [1:0]        axil_bresp,
    input  logic              axil_bvalid,
    output logic              axil_bready,
    output logic [ADDR_W-1:0] axil_araddr,
    output logic [2:0]        axil_arprot,
    output logic              axil_arvalid,
    input  logic              axil_arready,
    input  logic [DATA_W-1:0] axil_rdata,
    input  logic [1:0]        axil_rresp,
    input  logic              axil_rvalid,
    output logic              axil_rready
);
    state_e            state_q, state_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        resp_q, resp_d;
    logic              to_q, to_d;
    logic              clear, run, expired, abort;

    assign cmd_ready    = (state_q == IDLE) && !rst;
    assign axil_awvalid = (state_q == WR) && !aw_done_q;
    assign axil_wvalid  = (state_q == WR) && !w_done_q;
    assign axil_bready  = state_q == WR_B;
    assign axil_arvalid = state_q == RD_AR;
    assign axil_rready  = state_q == RD_R;
    assign axil_awaddr  = addr_q;
    assign axil_araddr  = addr_q;
    assign axil_awprot  = 3'b000;
    assign axil_arprot  = 3'b000;
    assign axil_wdata   = wdata_q;
    assign axil_wstrb   = wstrb_q;
    assign rsp_valid    = state_q == RSP;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;
    assign rsp_timeout  = to_q;
    assign run = (state_q == WR) || (state_q == WR_B) || (state_q == RD_AR) || (state_q == RD_R);

    axil_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .run     (run),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        to_d      = to_q;
        clear     = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                clear     = 1'b1;
                addr_d    = cmd_addr;
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = cmd_write ? WR : RD_AR;
            end
            WR: begin
                aw_done_d = aw_done_q || (axil_awvalid && axil_awready);
                w_done_d  = w_done_q || (axil_wvalid && axil_wready);
                if (aw_done_d && w_done_d) state_d = WR_B;
                else abort = expired;
            end
            WR_B: if (axil_bvalid) begin
                state_d = RSP;
                rdata_d = '0;
                resp_d  = axil_bresp;
                to_d    = 1'b0;
            end else abort = expired;
            RD_AR: if (axil_arready) state_d = RD_R;
                   else abort = expired;
            RD_R: if (axil_rvalid) begin
                state_d = RSP;
                rdata_d = axil_rdata;
                resp_d  = axil_rresp;
                to_d    = 1'b0;
            end else abort = expired;
            RSP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = RSP;
            rdata_d = '0;
            resp_d  = RESP_SLVERR;
            to_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            to_q      <= to_d;
        end
    end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed tests against a small register-file AXI4-Lite slave model
module tb_axil_cmd_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [31:0] wdata, rdata = '0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    int          n_checks = 0, n_fail = 0;
    int          aw_lat = 0, w_lat = 0, b_hs = 0;
    bit          silent = 1'b0, silent_b = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    axil_cmd_master #(.ADDR_W(16), .DATA_W(32), .STRB_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .axil_awaddr(awaddr), .axil_awprot(awprot), .axil_awvalid(awvalid), .axil_awready(awready),
        .axil_wdata(wdata), .axil_wstrb(wstrb), .axil_wvalid(wvalid), .axil_wready(wready),
        .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready),
        .axil_araddr(araddr), .axil_arprot(arprot), .axil_arvalid(arvalid), .axil_arready(arready),
        .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rsp_arrives", rsp_valid, 1);
    endtask

    task automatic end_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("cmd_ready_after_rsp", cmd_ready, 1);
    endtask

    // Slave reacts just after each rising edge, once the master's valids have settled
    initial begin
        int aw_cnt = 0, w_cnt = 0, aw_idx = 0, r_idx = 0;
        bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
        logic [31:0] w_d = '0;
        logic [3:0]  w_s = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            end else begin
                bvalid = b_pend && !silent_b;
                bresp  = cfg_bresp;
                if (bvalid && bready) begin b_pend = 0; b_hs++; end
                rvalid = r_pend;
                rdata  = mem[r_idx];
                rresp  = cfg_rresp;
                if (rvalid && rready) r_pend = 0;
                awready = 0;
                if (awvalid && !silent) begin
                    if (aw_cnt >= aw_lat) begin awready = 1; aw_idx = int'(awaddr[5:2]); aw_got = 1; aw_cnt = 0; end
                    else aw_cnt++;
                end else aw_cnt = 0;
                wready = 0;
                if (wvalid && !silent) begin
                    if (w_cnt >= w_lat) begin wready = 1; w_d = wdata; w_s = wstrb; w_got = 1; w_cnt = 0; end
                    else w_cnt++;
                end else w_cnt = 0;
                if (aw_got && w_got) begin
                    for (int i = 0; i < 4; i++) if (w_s[i]) mem[aw_idx][8*i +: 8] = w_d[8*i +: 8];
                    aw_got = 0; w_got = 0; b_pend = 1;
                end
                arready = arvalid && !silent;
                if (arready) begin r_idx = int'(araddr[5:2]); r_pend = 1; end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, first_w, first_aw, b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 0);
        check("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);
        check("prot", {awprot, arprot}, 0);

        start_cmd(1'b1, 16'h4, 32'h0000_1234, 4'hF);
        wait_rsp(n);
        check("wr_latency", n, 2);
        check("wr_resp", rsp_resp, 2'b00);
        check("wr_rdata", rsp_rdata, 0);
        end_rsp;

        start_cmd(1'b0, 16'h4, '0, '0);
        wait_rsp(n);
        check("rd_latency", n, 2);
        check("rd_rdata", rsp_rdata, 32'h0000_1234);
        check("rd_timeout", rsp_timeout, 0);
        end_rsp;

        aw_lat = 3; b0 = b_hs; first_w = -1; first_aw = -1;
        start_cmd(1'b1, 16'hC, 32'hCAFE_0001, 4'h3);
        for (int k = 0; k < 20 && !rsp_valid; k++) begin
            if (!wvalid && first_w < 0) first_w = k;
            if (!awvalid && first_aw < 0) first_aw = k;
            @(negedge clk);
        end
        check("late_aw_rsp", rsp_valid, 1);
        check("wvalid_drop", first_w, 1);
        check("awvalid_drop", first_aw, 4);
        check("b_handshakes", b_hs - b0, 1);
        check("late_aw_resp", rsp_resp, 2'b00);
        end_rsp;
        aw_lat = 0;

        start_cmd(1'b0, 16'hC, '0, '0);
        wait_rsp(n);
        check("strobe_rdata", rsp_rdata, 32'h0000_0001);
        end_rsp;

        cfg_bresp = 2'b11;
        start_cmd(1'b1, 16'h10, 32'h55, 4'hF);
        wait_rsp(n);
        check("bresp_pass", rsp_resp, 2'b11);
        check("bresp_rdata0", rsp_rdata, 0);
        end_rsp;
        cfg_bresp = 2'b00;

        silent = 1'b1;
        start_cmd(1'b0, 16'h8, '0, '0);
        check("to_arvalid_on", arvalid, 1);
        wait_rsp(n);
        check("to_latency", n, 8);
        check("to_arvalid_off", arvalid, 0);
        check("to_flag", rsp_timeout, 1);
        check("to_resp", rsp_resp, 2'b10);
        check("to_rdata", rsp_rdata, 0);
        end_rsp;
        silent = 1'b0;

        cfg_rresp = 2'b10;
        start_cmd(1'b0, 16'h8, '0, '0);
        wait_rsp(n);
        check("rresp_slverr", rsp_resp, 2'b10);
        check("rresp_no_timeout", rsp_timeout, 0);
        end_rsp;
        cfg_rresp = 2'b00;

        start_cmd(1'b0, 16'h4, '0, '0);
        wait_rsp(n);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, 32'h0000_1234);
            check("hold_cmd_ready", cmd_ready, 0);
            cmd_valid = (k == 2); cmd_write = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        end_rsp;
        check("no_queued_cmd", {awvalid, wvalid, arvalid}, 0);
        @(negedge clk);
        check("no_queued_cmd2", {awvalid, wvalid, arvalid, cmd_ready}, 1);

        silent_b = 1'b1;
        start_cmd(1'b1, 16'h14, 32'hDEAD_BEEF, 4'hF);
        for (int k = 0; k < 10 && !bready; k++) @(negedge clk);
        check("reach_wr_b", bready, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 0);
        rst = 1'b0;
        silent_b = 1'b0;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 1);

        start_cmd(1'b0, 16'h14, '0, '0);
        wait_rsp(n);
        check("post_rst_read", rsp_rdata, 32'hDEAD_BEEF);
        end_rsp;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
